pdm_decimator: RTL and testbench
================================

// Module: pdm_decimator
// PURPOSE
//  Receive side of the 1-bit delta-sigma audio path. Generates the clock for an external
//  PDM microphone and samples its 1-bit stream. Decimates the stream to signed 16-bit PCM
//  with a 3rd-order CIC filter. Defaults give a 3.125 MHz PDM clock and ~48.8 kHz output,
//  feeding the same sample-domain logic that drives the DAC.
// PARAMETERS
//  CLK_DIV    32  clk cycles per pdm_clk period; even, >= 8
//  DECIM      64  PDM bits per output sample; power of 2, 8..256
//  OUT_WIDTH  16  output sample width; must satisfy 3*log2(DECIM)+1 >= OUT_WIDTH
// PORTS
//  clk           input   1          system clock (100 MHz)
//  rst           input   1          asynchronous, active-high reset
//  enable        input   1          run capture; low = idle and flush
//  pdm_clk       output  1          clock to the microphone
//  pdm_data      input   1          microphone data (asynchronous to clk)
//  sample_out    output  OUT_WIDTH  signed PCM sample
//  sample_valid  output  1          one-cycle pulse: sample_out is new
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high. rst high immediately clears all
//   state: pdm_clk=0, sample_out=0, sample_valid=0, counters/integrators/combs=0, state=IDLE.
//   Reset mid-pipeline emits no partial sample.
//  Divider: div_cnt counts 0..CLK_DIV-1 while enable=1 and is 0 in the first enabled cycle.
//   pdm_clk=1 iff div_cnt >= CLK_DIV/2 (registered, 50% duty).
//  Input: pdm_data passes a 2-FF synchronizer. Bit strobe = the cycle with div_cnt==CLK_DIV-1,
//   at the end of the high phase. The synced bit maps 1 -> +1 and 0 -> -1.
//  Width: W = 3*log2(DECIM)+2 (20 for the defaults). All CIC arithmetic is two's-complement
//   mod 2^W; integrator wrap is intended and must not saturate.
//  Integrators: on each bit strobe, i1+=x, i2+=i1_new, i3+=i2_new.
//  Decimation: dec_cnt counts bit strobes 0..DECIM-1. The strobe with dec_cnt==DECIM-1 is the
//   decimation strobe; it latches i3 into the comb pipeline.
//  Combs: 3 stages, differential delay 1 (c_k = in_k - prev_in_k), one stage per clk cycle,
//   then an output register.
//  Scaling: y = comb3 >>> (3*log2(DECIM)+1-OUT_WIDTH), saturated to
//   [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Full scale +DECIM^3 gives 32767.
//  Latency: sample_valid is high exactly 4 clk cycles after the decimation strobe.
//   sample_out updates in that same cycle and holds until the next update.
//  Output rate: one sample per CLK_DIV*DECIM clk cycles (2048 for the defaults).
//   No backpressure: the downstream consumer must take every pulse.
//  FSM:
//   IDLE: enable=0. pdm_clk=0; div/dec counters, integrators and combs held at 0;
//    sample_valid=0; sample_out holds its last value. enable=1 -> SETTLE.
//   SETTLE: the filter runs, but the first 3 decimation outputs are suppressed (no
//    sample_valid, sample_out unchanged). 3rd decimation strobe -> RUN.
//   RUN: every decimation output is emitted.
//   Any state: enable=0 -> IDLE on the next cycle; in-flight comb results are dropped.
//  Simultaneous events: rst overrides everything. enable falling on a decimation strobe
//   produces no pulse.
// TESTING
//  1. enable=1, pdm_data=1 constant -> first sample_valid at cycle 4*DECIM*CLK_DIV+3 after
//     the first enabled cycle. sample_out=32767 (saturated); pulses every 2048 cycles.
//  2. pdm_data=0 constant -> every emitted sample_out=-32768; no wrap artefacts over 1000
//     samples.
//  3. Repeating 1,0 pattern synced to pdm_clk -> sample_out=0. Repeating 1,1,1,0 -> 16384.
//     Repeating 1,0,0,0 -> -16384.
//  4. Check pdm_clk: period 32 cycles, 16 high/16 low, 0 while enable=0. No sample_valid
//     during the first 3 decimation periods after enable rises.
//  5. Assert rst asynchronously 2 cycles after a decimation strobe -> outputs 0 immediately,
//     no pulse. After release and enable, behaviour matches scenario 1 timing.
//  6. Drop enable mid-frame and re-raise it 100 cycles later -> no pulse in between,
//     pdm_clk low, SETTLE repeats (3 suppressed outputs), and values match a fresh start.

Source files
------------

// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM microphone clock, input sync and 3rd-order CIC
// decimator to saturated signed PCM, with settle-time suppression.
module pdm_decimator #(
  parameter int CLK_DIV   = 32,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        pdm_clk,
  input  logic                        pdm_data,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid
);
  localparam int LD  = $clog2(DECIM);
  localparam int W   = 3*LD+2;
  localparam int SH  = 3*LD+1-OUT_WIDTH;
  localparam int DVW = $clog2(CLK_DIV);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV-1);
  localparam logic [DVW-1:0] DIV_HALF = DVW'(CLK_DIV/2);
  localparam logic [LD-1:0]  DEC_LAST = LD'(DECIM-1);
  localparam logic signed [W-1:0] YMAX = W'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [W-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t state, state_nxt;
  logic [1:0] settle_cnt;
  logic [DVW-1:0] div_cnt, div_nxt;
  logic [LD-1:0] dec_cnt;
  logic bit_stb, dec_stb;
  logic sync1, sync2;
  logic signed [W-1:0] x, i1, i2, i3, i1n, i2n, i3n;
  logic signed [W-1:0] d0, d1, d2, c1, c2, c3, sh;
  logic v1, v2, v3, e1, e2, e3;
  logic signed [OUT_WIDTH-1:0] y;

  // Divider step, strobes and integrator adder chain.
  always_comb begin
    div_nxt = '0;
    if (enable && div_cnt != DIV_LAST)
      div_nxt = div_cnt + 1'b1;
    bit_stb = enable && (div_cnt == DIV_LAST);
    dec_stb = bit_stb && (dec_cnt == DEC_LAST);
    x   = sync2 ? W'(1) : '1;
    i1n = i1 + x;
    i2n = i2 + i1n;
    i3n = i3 + i2n;
  end

  // Scale the last comb stage and clamp to the output range.
  always_comb begin
    sh = c3 >>> SH;
    if (sh > YMAX)
      y = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sh < YMIN)
      y = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      y = sh[OUT_WIDTH-1:0];
  end

  // Next state: enable low always returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (dec_stb && settle_cnt == 2'd2) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!enable)
      state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counts decimation outputs swallowed while the filter fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      settle_cnt <= '0;
    else if (!enable || state == IDLE)
      settle_cnt <= '0;
    else if (state == SETTLE && dec_stb)
      settle_cnt <= settle_cnt + 1'b1;
  end

  // Clock divider, registered pdm_clk and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
      dec_cnt <= '0;
    end else begin
      div_cnt <= div_nxt;
      pdm_clk <= (div_nxt >= DIV_HALF);
      if (!enable)
        dec_cnt <= '0;
      else if (bit_stb)
        dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous mic data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_data;
      sync2 <= sync1;
    end
  end

  // Integrators advance once per bit and wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (!enable) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (bit_stb) begin
      i1 <= i1n;
      i2 <= i2n;
      i3 <= i3n;
    end
  end

  // Comb pipeline, one stage per clock; emit tag follows the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {d0, d1, d2, c1, c2, c3} <= '0;
      {v1, v2, v3, e1, e2, e3} <= '0;
    end else if (!enable) begin
      {d0, d1, d2, c1, c2, c3} <= '0;
      {v1, v2, v3, e1, e2, e3} <= '0;
    end else begin
      v1 <= dec_stb;
      e1 <= (state == RUN);
      v2 <= v1;
      e2 <= e1;
      v3 <= v2;
      e3 <= e2;
      if (dec_stb) begin
        d0 <= i3n;
        c1 <= i3n - d0;
      end
      if (v1) begin
        d1 <= c1;
        c2 <= c1 - d1;
      end
      if (v2) begin
        d2 <= c2;
        c3 <= c2 - d2;
      end
    end
  end

  // Output register: update and pulse only for emitted results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= enable && v3 && e3;
      if (enable && v3 && e3)
        sample_out <= y;
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: scoreboard bench for the PDM decimator.
// Expected sample times and values come from pattern means.
`timescale 1ns/1ps
module tb_pdm_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic pdm_data = 1'b0;
  logic pdm_clk, sample_valid;
  logic signed [15:0] sample_out;

  int vectors = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    logic signed [15:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pdm_decimator dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .pdm_clk(pdm_clk),
    .pdm_data(pdm_data),
    .sample_out(sample_out),
    .sample_valid(sample_valid)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog");
  end

  // Enable with a repeating bit pattern for ncyc cycles; cycle 0 is
  // the first enabled cycle. Emitted samples are due at 2048*j+3, j>=4.
  task automatic run_enabled(input logic [3:0] pat, input int plen,
                             input int ncyc,
                             input logic signed [15:0] expv,
                             input string name);
    int cyc;
    int bad;
    exp_t e;
    cyc = 0;
    bad = 0;
    for (int j = 4; 2048*j+3 <= ncyc; j++) begin
      e.cyc = 2048*j+3;
      e.val = expv;
      sb.push_back(e);
    end
    enable = 1'b1;
    pdm_data = pat[0];
    while (cyc < ncyc) begin
      @(posedge clk);
      #1;
      cyc++;
      pdm_data = pat[2'((cyc/32) % plen)];
      if (pdm_clk !== ((cyc % 32) >= 16)) bad++;
      if (sample_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_spurious: valid at cycle %0d out=%0d, required no pulse",
                   name, cyc, sample_out);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL %s_latency: valid at cycle %0d, required %0d",
                     name, cyc, e.cyc);
          end
          vectors++;
          if (sample_out !== e.val) begin
            errors++;
            $display("FAIL %s_value: sample_out=%0d, required %0d",
                     name, sample_out, e.val);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
        vectors++;
        errors++;
        $display("FAIL %s_missing: no valid at cycle %0d, required pulse",
                 name, cyc);
        e = sb.pop_front();
      end
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_pdm_clk: %0d bad cycles, required 0", name, bad);
    end
    vectors++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending: %0d samples outstanding, required 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  // Hold enable low and require silence and a low pdm_clk.
  task automatic idle_check(input int n, input string name);
    int bad;
    bad = 0;
    enable = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sample_valid !== 1'b0 || pdm_clk !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s: %0d active cycles while idle, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: got %0d, required 0", sample_out);
    end
    vectors++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", sample_valid);
    end
    vectors++;
    if (pdm_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_pdm_clk: got %b, required 0", pdm_clk);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_const_one();
    run_enabled(4'b1111, 1, 10243, 16'sd32767, "ones");
    idle_check(4, "ones_idle");
  endtask

  task automatic test_const_zero();
    run_enabled(4'b0000, 1, 10243, -16'sd32768, "zeros");
    idle_check(4, "zeros_idle");
  endtask

  task automatic test_patterns();
    run_enabled(4'b0001, 2, 8195, 16'sd0, "pat10");
    idle_check(4, "pat10_idle");
    run_enabled(4'b0111, 4, 8195, 16'sd16384, "pat1110");
    idle_check(4, "pat1110_idle");
    run_enabled(4'b0001, 4, 8195, -16'sd16384, "pat1000");
    idle_check(4, "pat1000_idle");
  endtask

  task automatic test_reset_midpipe();
    run_enabled(4'b1111, 1, 8193, 16'sd32767, "rst_pre");
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL rst_async_out: got %0d, required 0", sample_out);
    end
    vectors++;
    if (sample_valid !== 1'b0 || pdm_clk !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_ctl: valid=%b pdm_clk=%b, required 0 0",
               sample_valid, pdm_clk);
    end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check(6, "rst_nopulse");
    run_enabled(4'b1111, 1, 8195, 16'sd32767, "rst_post");
    idle_check(4, "rst_post_idle");
  endtask

  task automatic test_reenable();
    run_enabled(4'b0111, 4, 10239, 16'sd16384, "reen_pre");
    idle_check(100, "reen_gap");
    run_enabled(4'b0111, 4, 10243, 16'sd16384, "reen_post");
    idle_check(4, "reen_idle");
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_const_zero();
    test_patterns();
    test_reset_midpipe();
    test_reenable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
